// File: rtl/mips_fetch.sv
// mips_fetch: single-outstanding MIPS instruction fetch that holds each instruction
// until downstream consumes it, computes next pc from branch/jump and times out on memory.
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic        imem_err,
  output logic [15:0] fetch_cnt
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERR} state_t;
  localparam logic [7:0] TO = 8'(TIMEOUT);
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr;
  logic [31:0] w_pcplus4, w_pcbranch, w_pcjump, w_next_pc;
  logic [7:0]  r_wait, w_wait_inc;
  logic [15:0] r_cnt;
  logic        r_err, w_hs, w_timeout, w_fetch;
  assign w_pcplus4  = r_pc + 32'd4;
  assign w_pcbranch = w_pcplus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_pcjump   = {w_pcplus4[31:28], r_instr[25:0], 2'b00};
  assign w_next_pc  = jump ? w_pcjump : pcsrc ? w_pcbranch : w_pcplus4;
  assign w_wait_inc = r_wait + 8'd1;
  assign w_timeout  = w_wait_inc == TO;
  assign w_fetch    = r_state == FETCH;
  assign w_hs       = r_state == HOLD && instr_ready;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = FETCH;
      FETCH:   w_next = imem_rvalid ? HOLD : w_timeout ? ERR : FETCH;
      HOLD:    w_next = instr_ready ? FETCH : HOLD;
      default: w_next = ERR;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
      r_wait  <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_fetch) r_wait <= imem_rvalid ? 8'd0 : w_wait_inc;
      if (w_fetch && imem_rvalid) r_instr <= imem_rdata;
      // a response arriving on the timeout cycle still wins
      if (w_fetch && !imem_rvalid && w_timeout) r_err <= 1'b1;
      if (w_hs) begin
        r_pc  <= w_next_pc;
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end
  assign imem_req    = w_fetch;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr       = r_instr;
  assign instr_valid = r_state == HOLD;
  assign imem_err    = r_err;
  assign fetch_cnt   = r_cnt;
endmodule

// File: tb/tb_mips_fetch.sv
// tb_mips_fetch: directed literal checks plus randomized traffic against a behavioural fetch model.
module tb_mips_fetch;
  localparam int TO = 4;
  logic        clk = 1'b0, rst;
  logic        imem_req, imem_rvalid, instr_valid, instr_ready, pcsrc, jump, imem_err;
  logic [31:0] imem_addr, imem_rdata, instr, pc;
  logic [15:0] fetch_cnt;
  int          n_cmp = 0, n_bad = 0;
  bit          chk_on = 0;
  mips_fetch #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr(instr),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .pcsrc(pcsrc),
    .jump(jump), .pc(pc), .imem_err(imem_err), .fetch_cnt(fetch_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  // model: waiting to start, fetching (counting misses), holding, or dead
  bit          m_started, m_have, m_err;
  int          m_waited;
  logic [31:0] m_pc, m_instr;
  logic [15:0] m_cnt;
  function automatic logic [31:0] target(input logic [31:0] p, input logic [31:0] i, input bit j, input bit s);
    logic [31:0] seq;
    int off;
    seq = p + 32'd4;
    off = $signed(i[15:0]);
    if (j) return (seq & 32'hF000_0000) | ((i & 32'h03FF_FFFF) << 2);
    if (s) return seq + 32'(off * 4);
    return seq;
  endfunction
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started = 0; m_have = 0; m_err = 0; m_waited = 0;
      m_pc = 32'h0; m_instr = 32'h0; m_cnt = 16'h0;
    end else if (!m_started) m_started = 1;
    else if (m_err) begin
    end else if (m_have) begin
      if (instr_ready) begin
        m_pc = target(m_pc, m_instr, jump, pcsrc);
        m_cnt = m_cnt + 16'd1;
        m_have = 0;
      end
    end else if (imem_rvalid) begin
      m_instr = imem_rdata; m_have = 1; m_waited = 0;
    end else begin
      m_waited++;
      if (m_waited == TO) m_err = 1;
    end
  end
  always @(negedge clk) if (chk_on) begin
    chk("model_req", imem_req, 32'(m_started && !m_have && !m_err));
    chk("model_addr", imem_addr, m_pc);
    chk("model_pc", pc, m_pc);
    chk("model_valid", instr_valid, 32'(m_have));
    chk("model_instr", instr, m_instr);
    chk("model_err", imem_err, 32'(m_err));
    chk("model_cnt", fetch_cnt, 32'(m_cnt));
  end
  // precondition: in HOLD; consumes held instr and fetches rd at the new pc
  task automatic hs(input logic [31:0] rd, input bit j, input bit s, input logic [31:0] epc, input logic [15:0] ecnt);
    tick(); instr_ready = 1; jump = j; pcsrc = s; imem_rdata = rd;
    tick(); instr_ready = 0; jump = 0; pcsrc = 0;
    @(negedge clk);
    chk("hs_req", imem_req, 1); chk("hs_addr", imem_addr, epc); chk("hs_cnt", fetch_cnt, 32'(ecnt));
    @(negedge clk);
    chk("hs_valid", instr_valid, 1); chk("hs_instr", instr, rd); chk("hs_pc", pc, epc);
  endtask
  initial begin
    rst = 1; imem_rvalid = 1; imem_rdata = 32'h2008_0005; instr_ready = 0; pcsrc = 0; jump = 0;
    repeat (2) @(posedge clk);
    chk_on = 1;
    @(negedge clk);
    chk("rst_pc", pc, 0); chk("rst_instr", instr, 0); chk("rst_valid", instr_valid, 0);
    chk("rst_req", imem_req, 0); chk("rst_err", imem_err, 0); chk("rst_cnt", fetch_cnt, 0);
    tick(); rst = 0;
    @(negedge clk); chk("start_c1_req", imem_req, 0);
    @(negedge clk); chk("start_c2_req", imem_req, 1); chk("start_c2_addr", imem_addr, 0);
    @(negedge clk); chk("start_c3_valid", instr_valid, 1); chk("start_c3_instr", instr, 32'h2008_0005);
    repeat (5) begin
      tick(); imem_rdata = $urandom;
      @(negedge clk);
      chk("stall_instr", instr, 32'h2008_0005); chk("stall_pc", pc, 0);
      chk("stall_req", imem_req, 0); chk("stall_cnt", fetch_cnt, 0);
    end
    hs(32'h0800_0004, 0, 0, 32'h0000_0004, 1);
    hs(32'h1000_FFFF, 1, 0, 32'h0000_0010, 2);
    hs(32'h0800_0040, 0, 1, 32'h0000_0010, 3);
    hs(32'h0800_0004, 1, 1, 32'h0000_0100, 4);
    chk("model_pin_jump", m_pc, 32'h0000_0100);
    hs(32'h0000_0000, 1, 0, 32'h0000_0010, 5);
    hs(32'h1000_FFF9, 0, 0, 32'h0000_0014, 6);
    hs(32'h0000_0000, 0, 1, 32'hFFFF_FFFC, 7);
    chk("model_pin_branch", m_pc, 32'hFFFF_FFFC);
    hs(32'h0000_0000, 0, 0, 32'h0000_0000, 8);
    tick(); instr_ready = 1; imem_rvalid = 0;
    tick(); instr_ready = 0;
    repeat (4) begin
      @(negedge clk); chk("to_wait_req", imem_req, 1); chk("to_wait_err", imem_err, 0);
    end
    @(negedge clk); chk("to_err", imem_err, 1); chk("to_req", imem_req, 0); chk("to_valid", instr_valid, 0);
    tick(); imem_rvalid = 1; instr_ready = 1;
    repeat (3) @(negedge clk);
    chk("err_stuck", imem_err, 1); chk("err_req", imem_req, 0);
    chk("err_valid", instr_valid, 0); chk("err_cnt", fetch_cnt, 9);
    tick(); rst = 1; instr_ready = 0; imem_rvalid = 0; imem_rdata = 32'hCAFE_0001;
    #1;
    chk("arst_pc", pc, 0); chk("arst_err", imem_err, 0); chk("arst_req", imem_req, 0); chk("arst_cnt", fetch_cnt, 0);
    tick(); rst = 0;
    repeat (4) tick();
    imem_rvalid = 1;
    @(negedge clk); chk("edge_req", imem_req, 1); chk("edge_err", imem_err, 0);
    @(negedge clk); chk("edge_valid", instr_valid, 1); chk("edge_instr", instr, 32'hCAFE_0001); chk("edge_err2", imem_err, 0);
    hs(32'h0800_0010, 0, 0, 32'h0000_0004, 1);
    tick(); instr_ready = 1; jump = 1; imem_rvalid = 0;
    tick(); instr_ready = 0; jump = 0;
    @(negedge clk); chk("mid_addr", imem_addr, 32'h0000_0040); chk("mid_req", imem_req, 1);
    tick(); rst = 1; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("mid_rst_pc", pc, 0); chk("mid_rst_req", imem_req, 0); chk("mid_rst_valid", instr_valid, 0);
    tick(); rst = 0;
    @(negedge clk); chk("stale_req", imem_req, 0); chk("stale_valid", instr_valid, 0);
    @(negedge clk); chk("restart_req", imem_req, 1); chk("restart_addr", imem_addr, 0);
    @(negedge clk); chk("restart_valid", instr_valid, 1); chk("restart_instr", instr, 32'hDEAD_BEEF);
    repeat (4000) begin
      tick();
      rst = $urandom_range(0, 149) == 0;
      imem_rvalid = $urandom_range(0, 3) != 0;
      imem_rdata = $urandom;
      instr_ready = $urandom_range(0, 1) == 1;
      jump = $urandom_range(0, 3) == 0;
      pcsrc = $urandom_range(0, 3) == 0;
    end
    tick(); rst = 0;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_fetch.md
MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 SHALL have parameter TIMEOUT, default 16, giving the maximum cycles to wait for imem_rvalid; legal range 1..255.
REQ-003 SHALL have ports as follows, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  32  read address; equals pc.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  read data.
- instr  out  32  held instruction, fed to the controller.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  downstream consumes instr this cycle.
- pcsrc  in  1  branch-taken from the controller, relative to the held instr.
- jump  in  1  jump from the controller, relative to the held instr.
- pc  out  32  address of the held or in-flight instruction.
- imem_err  out  1  sticky fetch-timeout flag.
- fetch_cnt  out  16  count of consumed instructions.

Function
REQ-004 SHALL implement the states IDLE, FETCH, HOLD and ERR.
REQ-005 SHALL go IDLE -> FETCH unconditionally on the first clk after reset deasserts.
REQ-006 In FETCH, SHALL drive imem_req=1 with imem_addr=pc held stable until imem_rvalid.
- On imem_rvalid, SHALL load instr <= imem_rdata, clear the wait counter, and go to HOLD.
REQ-007 SHALL drive imem_req=0 in all states other than FETCH.
- SHALL ignore imem_rvalid outside FETCH.
REQ-008 In HOLD, SHALL drive instr_valid=1.
- instr and pc SHALL remain stable until instr_ready=1.
REQ-009 On instr_valid && instr_ready, SHALL update pc <= next_pc, increment fetch_cnt, and go to FETCH.
- The earliest next handshake is 2 cycles later: one FETCH cycle with zero-latency memory.
REQ-010 SHALL compute next_pc combinationally from pc and instr, all arithmetic mod 2^32:
- pcplus4 = pc + 4
- pcbranch = pcplus4 + (sign-extended instr[15:0] << 2)
- pcjump = {pcplus4[31:28], instr[25:0], 2'b00}
REQ-011 SHALL select next_pc with priority jump, then pcsrc, then pcplus4; jump and pcsrc SHALL be sampled only at the handshake cycle.
REQ-012 SHALL wrap pc from 32'hFFFF_FFFC to 32'h0000_0000 on the sequential path.
REQ-013 SHALL wrap fetch_cnt from 16'hFFFF to 16'h0000.
REQ-014 In FETCH, SHALL increment an 8-bit wait counter each cycle without imem_rvalid.
- When the counter reaches TIMEOUT, SHALL set imem_err=1 and go to ERR.
REQ-015 ERR SHALL be terminal: imem_req=0 and instr_valid=0; exit only via reset.
REQ-016 imem_rvalid in the same cycle the counter would reach TIMEOUT SHALL count as success: go to HOLD, imem_err stays 0.
REQ-017 instr_ready asserted while not in HOLD SHALL have no effect.

Reset
REQ-018 While rst=1, outputs SHALL be:
- pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, imem_err=0, fetch_cnt=0
- state=IDLE, wait counter=0
REQ-019 Reset asserted mid-FETCH or mid-HOLD SHALL abandon the operation immediately (asynchronously).
- A later imem_rvalid for the abandoned request SHALL be ignored until FETCH is re-entered.

Verification
REQ-020 Reset release with imem_rvalid tied to 1 and imem_rdata=32'h2008_0005 -> 1st cycle imem_req=0; 2nd cycle imem_req=1, imem_addr=0; 3rd cycle instr_valid=1, instr=32'h2008_0005.
REQ-021 Handshake at pc=32'h0000_0010, jump=0, pcsrc=0 -> next imem_addr=32'h0000_0014, fetch_cnt=1.
REQ-022 pc=32'h0000_0010, instr=32'h1000_FFFF, pcsrc=1 -> next pc=32'h0000_0010; pcsrc=1 with jump=1, instr=32'h0800_0040 -> next pc=32'h0000_0100 (jump priority).
REQ-023 instr_ready=0 held for 5 cycles in HOLD while imem_rdata changes -> instr, pc stable, imem_req=0, fetch_cnt unchanged.
REQ-024 TIMEOUT=4, imem_rvalid=0 -> imem_err=1 four cycles into FETCH, then state ERR with imem_req=0; rvalid exactly at that cycle -> HOLD, imem_err=0.
REQ-025 rst pulsed mid-FETCH at pc=32'h0000_0040 -> pc=RESET_PC immediately, stale rvalid ignored, fetch restarts at RESET_PC.
